// File: rtl/x_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : x_bus_ctrl
// Brief    : Core request port to SRAM, GPIO, cycle counter and TX byte FIFO.
// Revision : 1.0
// ============================================================================
module x_bus_ctrl #(
  parameter int MEM_AW   = 12,
  parameter int TX_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_valid,
  input  logic              i_rnw,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_data,
  output logic              o_accept,
  output logic [31:0]       o_data,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic [31:0]       o_gpio,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready
);

  localparam int             c_pw         = $clog2(TX_DEPTH);
  localparam logic [c_pw:0]  c_full_cnt   = (c_pw+1)'(TX_DEPTH);
  localparam logic [c_pw:0]  c_cnt_one    = (c_pw+1)'(1);
  localparam logic [c_pw-1:0] c_ptr_one   = c_pw'(1);
  localparam logic [0:0]     c_st_idle    = 1'b0;
  localparam logic [0:0]     c_st_rd_wait = 1'b1;
  localparam logic [1:0]     c_reg_gpio   = 2'd0;
  localparam logic [1:0]     c_reg_cycle  = 2'd1;
  localparam logic [1:0]     c_reg_txdata = 2'd2;
  localparam logic [1:0]     c_reg_status = 2'd3;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [31:0]     r_gpio;
  logic [31:0]     r_cycle;
  logic [7:0]      r_fifo [TX_DEPTH];
  logic [c_pw-1:0] r_wr_ptr;
  logic [c_pw-1:0] r_rd_ptr;
  logic [c_pw:0]   r_count;

  logic            w_periph;
  logic [1:0]      w_reg;
  logic            w_idle_req;
  logic            w_tx_full;
  logic            w_tx_empty;
  logic            w_tx_push;
  logic            w_tx_pop;
  logic            w_gpio_wr;
  logic [7:0]      w_cnt8;
  logic [31:0]     w_periph_rdata;

  assign w_periph   = i_addr[31];
  assign w_reg      = i_addr[3:2];
  assign w_idle_req = (r_state == c_st_idle) && i_valid;
  assign w_tx_full  = (r_count == c_full_cnt);
  assign w_tx_empty = (r_count == '0);
  assign w_cnt8     = 8'(r_count);

  assign w_tx_push  = o_accept && w_idle_req && w_periph && !i_rnw && (w_reg == c_reg_txdata);
  assign w_gpio_wr  = o_accept && w_idle_req && w_periph && !i_rnw && (w_reg == c_reg_gpio);
  assign w_tx_pop   = !w_tx_empty && i_tx_ready;

  assign o_mem_addr  = i_nrst ? i_addr[MEM_AW+1:2] : '0;
  assign o_mem_wdata = i_nrst ? i_data : '0;
  assign o_gpio      = r_gpio;
  assign o_tx_valid  = !w_tx_empty;
  assign o_tx_data   = w_tx_empty ? 8'd0 : r_fifo[r_rd_ptr];

  always_comb begin
    w_periph_rdata = 32'd0;
    case (w_reg)
      c_reg_gpio:   w_periph_rdata = r_gpio;
      c_reg_cycle:  w_periph_rdata = r_cycle;
      c_reg_status: w_periph_rdata = {16'd0, w_cnt8, 6'd0, w_tx_full, w_tx_empty};
      default:      w_periph_rdata = 32'd0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_state <= c_st_idle;
    else         r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:    if (i_valid && i_rnw && !w_periph) w_state_nxt = c_st_rd_wait;
      c_st_rd_wait: w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  // FSM: outputs; everything is held low while reset is asserted
  always_comb begin
    o_accept = 1'b0;
    o_data   = 32'd0;
    o_mem_en = 1'b0;
    o_mem_we = 1'b0;
    if (i_nrst) begin
      case (r_state)
        c_st_rd_wait: begin
          o_accept = 1'b1;
          o_data   = i_mem_rdata;
        end
        default: begin
          if (i_valid && !w_periph) begin
            o_mem_en = 1'b1;
            o_mem_we = !i_rnw;
            o_accept = !i_rnw;
          end else if (i_valid) begin
            o_accept = !(!i_rnw && (w_reg == c_reg_txdata) && w_tx_full);
            o_data   = i_rnw ? w_periph_rdata : 32'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_gpio  <= 32'd0;
      r_cycle <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_gpio_wr) r_gpio <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_tx_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_tx_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: o_tx_data is masked while the FIFO is empty
  always_ff @(posedge i_clk) begin
    if (w_tx_push) r_fifo[r_wr_ptr] <= i_data[7:0];
  end

endmodule
`default_nettype wire

// File: doc/x_bus_ctrl.md
Name: x_bus_ctrl

Overview:
Memory/peripheral bus controller sitting directly downstream of the rv32i core's single request port (valid/rnw/addr/data, accept/rdata).
- Services every core request: fetches, loads and stores.
- Routes requests to an external synchronous single-port SRAM macro or to a small local peripheral set: GPIO output register, free-running cycle counter, byte TX FIFO with status.
- Supplies read data in the same cycle it asserts accept, because the core captures read data on the accept cycle.

Parameters:
MEM_AW, 12, SRAM word-address width (2^MEM_AW 32-bit words).
TX_DEPTH, 4, TX FIFO depth in entries; must be a power of two, minimum 2.

Ports:
i_clk  in  1  clock.
i_nrst  in  1  asynchronous active-low reset.
i_valid  in  1  core request valid; held until accepted.
i_rnw  in  1  1 = read, 0 = write.
i_addr  in  32  byte address; bits [1:0] ignored (word access only).
i_data  in  32  core write data.
o_accept  out  1  request completes this cycle.
o_data  out  32  read data, valid when o_accept & i_rnw.
o_mem_en  out  1  SRAM access strobe.
o_mem_we  out  1  SRAM write enable (qualified by o_mem_en).
o_mem_addr  out  MEM_AW  SRAM word address = i_addr[MEM_AW+1:2].
o_mem_wdata  out  32  SRAM write data = i_data.
i_mem_rdata  in  32  SRAM read data, valid one cycle after a read strobe.
o_gpio  out  32  GPIO output register.
o_tx_valid  out  1  TX FIFO not empty.
o_tx_data  out  8  FIFO head byte.
i_tx_ready  in  1  consumer takes head when high with o_tx_valid.

Behaviour:
Address map:
- i_addr[31]=0: SRAM.
- i_addr[31]=1: peripherals, selected by i_addr[3:2]:
  - 0: GPIO, read/write.
  - 1: CYCLE, read-only; writes are accepted and dropped.
  - 2: TXDATA, write-only; a write pushes i_data[7:0]; reads return 0.
  - 3: STATUS, read-only; value = {16'd0, count zero-extended to 8b in [15:8], 6'd0, full, empty}.
- Other i_addr bits in peripheral space are ignored.

FSM states: IDLE, RD_WAIT.
- IDLE, i_valid & i_rnw & SRAM: o_mem_en=1, o_mem_we=0, o_accept=0; go to RD_WAIT.
- RD_WAIT: o_accept=1, o_data=i_mem_rdata, SRAM not strobed; go to IDLE unconditionally. Read latency is 2 cycles, valid to accept inclusive.
- IDLE, i_valid & ~i_rnw & SRAM: o_mem_en=1, o_mem_we=1, o_accept=1 in the same cycle; stay in IDLE.
- IDLE, i_valid & peripheral: o_accept=1 in the same cycle (combinational o_data); stay in IDLE.
  - Exception: a TXDATA write while full holds o_accept=0 until not full.
- Back-to-back requests: a new request may be presented in the cycle after accept; no idle gap is required.
- o_mem_en/o_mem_we are never asserted when i_valid=0.
- o_data=0 whenever o_accept=0 or the request is a write.

GPIO:
- Loads i_data on accepted write.
- Reset value 0.

CYCLE counter:
- 32b, increments every cycle, wraps 0xFFFFFFFF -> 0.
- Reset value 0.
- A read returns the pre-increment value in the accept cycle.

TX FIFO:
- Push on accepted TXDATA write.
- Pop on o_tx_valid & i_tx_ready.
- Push is accepted only when count < TX_DEPTH. A pop in the same cycle does not unblock a full FIFO.
- Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- Pointers wrap modulo TX_DEPTH.
- o_tx_data is 0 when empty.

Reset, asynchronous, any state:
- FSM returns to IDLE; an in-flight SRAM read is abandoned.
- FIFO empties; counter, GPIO and all outputs are 0.

Test Plan:
- SRAM read at 0x00000010, SRAM model returns 0x00000013 one cycle after strobe -> o_mem_addr=4 with o_mem_en=1, we=0 in cycle 0; o_accept=1, o_data=0x00000013 in cycle 1; exactly one strobe.
- SRAM write 0x00000020 <- 0xDEADBEEF, then read back -> write accepted in the same cycle with o_mem_addr=8, we=1; read returns 0xDEADBEEF after 2 cycles.
- GPIO write 0x80000000 <- 0x000000A5, then read 0x80000000 -> o_gpio=0xA5 the cycle after the write; the read returns 0xA5 with zero-wait accept.
- Five TXDATA writes 0x11..0x15 with i_tx_ready=0 -> first four accepted, STATUS=0x00000402, fifth stalls with o_accept=0. Raise i_tx_ready for one cycle -> 0x11 popped, fifth accepted the next cycle; drain order is 0x12, 0x13, 0x14, 0x15.
- Force counter to 0xFFFFFFFE via reset-release timing, read CYCLE on consecutive cycles -> returns 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Assert i_nrst=0 in the RD_WAIT cycle -> o_accept=0, o_data=0, FSM in IDLE. After release, the re-presented read takes the full 2 cycles.
